ram_bist: RTL and testbench
===========================

# ram_bist

Built-in self-test sequencer for the 32×8 `mem_RAM` block. It acts as the initiator on the RAM port: it writes an arithmetic data pattern into a programmable address range, reads the range back, and compares each word against the expected value. It sits beside `mem_RAM` in the datapath and takes over the RAM's D/Address/WE port while busy. It reports pass/fail, the error count and the first failing address to the control unit.

## Interface
Parameters:
- `AW`, 5: RAM address width (32 words).
- `DW`, 8: RAM data width.

Ports:
- `CLOCK` in 1: single clock; all state updates on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `START` in 1: begin a test; sampled only in IDLE or DONE.
- `SEED` in DW: data written to address 0; sampled with START.
- `STEP` in DW: increment between consecutive words; sampled with START.
- `LAST_ADDR` in AW: highest address tested (range 0..LAST_ADDR); sampled with START.
- `RAM_D` out DW: write data to RAM.
- `RAM_ADDR` out AW: RAM address.
- `RAM_WE` out 1: RAM write enable (1 = write on this edge).
- `RAM_Q` in DW: RAM read data; valid one cycle after the address is presented with `RAM_WE`=0.
- `BUSY` out 1: high from the first WRITE cycle through the CHECK cycle.
- `DONE` out 1: high while in DONE.
- `PASS` out 1: valid while DONE; 1 = zero mismatches.
- `ERR_COUNT` out AW+1: number of mismatching words (0..32, cannot overflow).
- `FIRST_ERR_ADDR` out AW: address of the first mismatch; 0 if there were none.

## Operation
- States: IDLE, WRITE, READ, CHECK, DONE.
- **IDLE / DONE, START=1:**
  - Latch SEED, STEP and LAST_ADDR.
  - Clear ERR_COUNT, FIRST_ERR_ADDR, PASS and DONE.
  - Set addr=0 and exp=SEED; go to WRITE.
- **IDLE / DONE, START=0:** hold. All RAM outputs are 0 (`RAM_WE`=0).
- **WRITE:**
  - Drive `RAM_WE`=1, `RAM_ADDR`=addr, `RAM_D`=SEED + addr·STEP, computed mod 2^DW by a running adder, not a multiplier.
  - At addr==LAST_ADDR: go to READ with addr=0. Otherwise addr+1.
- **READ:**
  - Drive `RAM_WE`=0, `RAM_ADDR`=addr.
  - Keep a one-stage pipeline holding the previous address and its expected value (valid flag cleared on READ entry).
  - Each cycle with the valid flag set: compare `RAM_Q` against the piped expected value.
  - At addr==LAST_ADDR: go to CHECK.
- **CHECK:**
  - Compare the final word; `RAM_WE`=0, `RAM_ADDR` held.
  - Next state DONE; PASS=(ERR_COUNT==0), including the final compare.
- **Mismatch handling:** each mismatch increments ERR_COUNT. On the first mismatch only (ERR_COUNT was 0), FIRST_ERR_ADDR is loaded with the piped address.
- **Address wrap:** addr arithmetic is AW bits. LAST_ADDR=31 covers the whole RAM with no wrap past 31. LAST_ADDR=0 tests the single word 0.
- **START while BUSY:** ignored; SEED/STEP/LAST_ADDR changes mid-test have no effect.
- **Expected-value wrap:** the pattern wraps mod 256, e.g. SEED=F0, STEP=20 gives F0, 10, 30, …

## Timing
- **Reset:** `RESET_N` low forces, asynchronously, IDLE and all outputs 0: `RAM_D`, `RAM_ADDR`, `RAM_WE`, BUSY, DONE, PASS, ERR_COUNT, FIRST_ERR_ADDR.
- **Reset mid-test:** aborts immediately; RAM contents are undefined afterwards; no DONE is issued.
- **Test length:** with N=LAST_ADDR+1 and START sampled at edge k:
  - WRITE occupies cycles k+1..k+N.
  - READ occupies k+N+1..k+2N.
  - CHECK is k+2N+1.
  - DONE=1 from edge k+2N+2.
  - Example: N=32 gives 66 cycles from START to DONE.
- **BUSY:** rises at edge k+1 and falls at the same edge DONE rises.
- **Read latency:** the compare for address a, presented in cycle c, uses `RAM_Q` sampled at edge c+1.
- **Restart:** DONE is held until START; START in DONE restarts with the same timing as from IDLE.

## Test plan
- **Full pass:** SEED=0F, STEP=02, LAST_ADDR=1F with a behavioural `mem_RAM` → 32 writes (0F, 11, …, 4D), DONE at +66 cycles, PASS=1, ERR_COUNT=0, FIRST_ERR_ADDR=0.
- **Stuck bit:** RAM model with bit 0 of word 05 stuck at 1; SEED=00, STEP=02, LAST_ADDR=0F → PASS=0, ERR_COUNT=1, FIRST_ERR_ADDR=05, DONE at +34.
- **Multiple faults:** words 03, 07 and 1F corrupted; full range → ERR_COUNT=3, FIRST_ERR_ADDR=03.
- **Single-word boundary:** LAST_ADDR=00, SEED=A5 → one write of A5 to address 0, DONE at +4, PASS=1. Wrap check: SEED=F0, STEP=20, LAST_ADDR=03 writes F0, 10, 30, 50.
- **Mid-test abort:** START, then `RESET_N` pulsed low during READ at address 08 → all outputs 0 within the reset; IDLE until a new START; the next full test passes normally.
- **Restart from DONE:** START pulsed again during BUSY with a different SEED → ignored. START issued in DONE → restarts and clears the previous ERR_COUNT/PASS.

Source files
------------

// File: rtl/ram_bist.sv
// Built-in self-test sequencer for the 32x8 mem_RAM block.
// Writes an arithmetic pattern, reads it back and counts mismatches.
module ram_bist #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  input  logic          START,
  input  logic [DW-1:0] SEED,
  input  logic [DW-1:0] STEP,
  input  logic [AW-1:0] LAST_ADDR,
  output logic [DW-1:0] RAM_D,
  output logic [AW-1:0] RAM_ADDR,
  output logic          RAM_WE,
  input  logic [DW-1:0] RAM_Q,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic [AW:0]   ERR_COUNT,
  output logic [AW-1:0] FIRST_ERR_ADDR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, nxt;

  logic [DW-1:0] seed_q, step_q;
  logic [AW-1:0] last_q;
  logic [AW-1:0] addr;
  logic [DW-1:0] exp;
  logic          pv;
  logic [AW-1:0] pa;
  logic [DW-1:0] pe;
  logic [AW:0]   err;
  logic [AW-1:0] ferr;
  logic          pass_q;
  logic          mis;
  logic          at_last;

  assign at_last = (addr == last_q);
  // pv is only ever set while reading, so it also gates the compare
  assign mis = pv && (RAM_Q != pe);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (START) nxt = S_WRITE;
      S_WRITE: if (at_last) nxt = S_READ;
      S_READ:  if (at_last) nxt = S_CHECK;
      S_CHECK: nxt = S_DONE;
      S_DONE:  if (START) nxt = S_WRITE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      seed_q <= '0;
      step_q <= '0;
      last_q <= '0;
      addr   <= '0;
      exp    <= '0;
      pv     <= 1'b0;
      pa     <= '0;
      pe     <= '0;
      err    <= '0;
      ferr   <= '0;
      pass_q <= 1'b0;
    end else begin
      pv <= (state == S_READ);
      pa <= addr;
      pe <= exp;
      if (mis) begin
        err <= err + (AW+1)'(1);
        if (err == '0) ferr <= pa;
      end
      unique case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            seed_q <= SEED;
            step_q <= STEP;
            last_q <= LAST_ADDR;
            addr   <= '0;
            exp    <= SEED;
            err    <= '0;
            ferr   <= '0;
            pass_q <= 1'b0;
          end
        end
        S_WRITE: begin
          if (at_last) begin
            addr <= '0;
            exp  <= seed_q;
          end else begin
            addr <= addr + AW'(1);
            exp  <= exp + step_q;
          end
        end
        S_READ: begin
          if (!at_last) begin
            addr <= addr + AW'(1);
            exp  <= exp + step_q;
          end
        end
        S_CHECK: pass_q <= (err == '0) && !mis;
        default: ;
      endcase
    end
  end

  assign BUSY           = (state == S_WRITE) || (state == S_READ)
                        || (state == S_CHECK);
  assign DONE           = (state == S_DONE);
  assign RAM_WE         = (state == S_WRITE);
  assign RAM_D          = RAM_WE ? exp : '0;
  assign RAM_ADDR       = BUSY ? addr : '0;
  assign PASS           = pass_q;
  assign ERR_COUNT      = err;
  assign FIRST_ERR_ADDR = ferr;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a behavioural 32x8 RAM
// that supports injected stuck-at and bit-flip faults.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = '0;
  logic [7:0] step = '0;
  logic [4:0] last = '0;
  logic [7:0] ram_d;
  logic [4:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_count;
  logic [4:0] ferr;

  logic [7:0] mem [32];
  logic [7:0] orm [32];
  logic [7:0] xm  [32];
  int         wr_cnt = 0;
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc;
  int         w0;

  always #5 clk = ~clk;

  ram_bist dut (
    .CLOCK          (clk),
    .RESET_N        (rst_n),
    .START          (start),
    .SEED           (seed),
    .STEP           (step),
    .LAST_ADDR      (last),
    .RAM_D          (ram_d),
    .RAM_ADDR       (ram_addr),
    .RAM_WE         (ram_we),
    .RAM_Q          (ram_q),
    .BUSY           (busy),
    .DONE           (done),
    .PASS           (pass),
    .ERR_COUNT      (err_count),
    .FIRST_ERR_ADDR (ferr)
  );

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_d;
      wr_cnt <= wr_cnt + 1;
    end
    ram_q <= (mem[ram_addr] | orm[ram_addr]) ^ xm[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic run(input logic [7:0] sd, input logic [7:0] st,
                     input logic [4:0] la, input bit poke,
                     output int c);
    @(posedge clk);
    #1;
    seed  = sd;
    step  = st;
    last  = la;
    start = 1'b1;
    c = 0;
    forever begin
      @(posedge clk);
      c++;
      #1;
      if (c == 1) start = 1'b0;
      if (poke && c == 5) begin
        start = 1'b1;
        seed  = 8'h55;
        step  = 8'h01;
        last  = 5'd0;
      end
      if (poke && c == 6) start = 1'b0;
      if (done || c >= 200) break;
    end
    check("latency", c, 2 * (int'(la) + 1) + 2);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      orm[i] = '0;
      xm[i]  = '0;
    end
    #12;
    check("reset_outs", {ram_d, ram_addr, ram_we, busy, done, pass,
                         err_count, ferr}, 0);
    rst_n = 1'b1;

    w0 = wr_cnt;
    run(8'h0F, 8'h02, 5'd31, 0, cyc);
    check("full_pass", pass, 1);
    check("full_err", err_count, 0);
    check("full_ferr", ferr, 0);
    check("full_writes", wr_cnt - w0, 32);
    check("full_mem0", mem[0], 8'h0F);
    check("full_mem1", mem[1], 8'h11);
    check("full_mem31", mem[31], 8'h4D);
    @(posedge clk);
    #1;
    check("done_held", {done, pass}, 2'b11);
    check("idle_ram", {ram_d, ram_addr, ram_we}, 0);

    orm[5] = 8'h01;
    run(8'h00, 8'h02, 5'd15, 0, cyc);
    check("stuck_pass", pass, 0);
    check("stuck_err", err_count, 1);
    check("stuck_ferr", ferr, 5);
    orm[5] = 8'h00;

    xm[3]  = 8'h80;
    xm[7]  = 8'h01;
    xm[31] = 8'h10;
    run(8'h3C, 8'h07, 5'd31, 0, cyc);
    check("multi_pass", pass, 0);
    check("multi_err", err_count, 3);
    check("multi_ferr", ferr, 3);
    xm[3]  = 8'h00;
    xm[7]  = 8'h00;
    xm[31] = 8'h00;

    run(8'h0F, 8'h02, 5'd31, 0, cyc);
    check("restart_pass", pass, 1);
    check("restart_err", err_count, 0);
    check("restart_ferr", ferr, 0);

    w0 = wr_cnt;
    run(8'hA5, 8'h00, 5'd0, 0, cyc);
    check("single_pass", pass, 1);
    check("single_writes", wr_cnt - w0, 1);
    check("single_mem0", mem[0], 8'hA5);

    run(8'hF0, 8'h20, 5'd3, 0, cyc);
    check("wrap_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'hF0103050);
    check("wrap_pass", pass, 1);

    run(8'h11, 8'h03, 5'd7, 1, cyc);
    check("poke_pass", pass, 1);
    check("poke_mem0", mem[0], 8'h11);
    check("poke_mem7", mem[7], 8'h26);

    @(posedge clk);
    #1;
    seed  = 8'h0F;
    step  = 8'h02;
    last  = 5'd31;
    start = 1'b1;
    cyc   = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) start = 1'b0;
      if ((busy && !ram_we && ram_addr == 5'd8) || cyc >= 100) break;
    end
    check("abort_reach", cyc < 100, 1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", {ram_d, ram_addr, ram_we, busy, done, pass,
                         err_count, ferr}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle", {busy, done, ram_we}, 0);

    run(8'h0F, 8'h02, 5'd31, 0, cyc);
    check("after_abort_pass", pass, 1);
    check("after_abort_err", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
